tdm_demux: RTL
==============

Name: tdm_demux

Overview:
- Receiving end of a time-division-multiplexed word stream: the counterpart to the mux-based selectors in the design.
- Takes one word per valid beat, interleaved across NCH channels, with a start-of-frame marker on slot 0.
- Deinterleaves the beats into per-channel holding registers, with per-channel update strobes and frame/sync status.
- Sits between a shared serial-data link and per-channel consumers.

Parameters:
- WIDTH, 8: data word width in bits.
- NCH, 4: number of channels per frame; power of 2, minimum 2.
- CW, 2: slot index width; must equal log2(NCH).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- din  input  WIDTH  incoming TDM data word.
- din_valid  input  1  din holds a valid beat this cycle.
- sof  input  1  start of frame; qualified only when din_valid=1; marks the beat as slot 0.
- dout  output  NCH*WIDTH  channel registers, flattened; channel k occupies bits [k*WIDTH +: WIDTH].
- dout_valid  output  NCH  one-cycle strobe; bit k is high the cycle after channel k is loaded.
- frame_done  output  1  one-cycle strobe, coincident with dout_valid[NCH-1].
- sync_err  output  1  one-cycle strobe: sof seen while the expected slot was not 0.
- locked  output  1  high while in LOCKED state.
- slot  output  CW  slot index expected for the next accepted beat.

Behaviour:
- Reset (async, rst=1): dout=0, dout_valid=0, frame_done=0, sync_err=0, locked=0, slot=0, state=HUNT. Outputs hold these values for as long as rst is high.
- All state updates occur on the rising clk edge. All outputs are registered. Latency is 1 cycle from the sampled beat to the visible dout/strobes.
- States: HUNT, LOCKED.
- HUNT:
  - din_valid=1 and sof=0: beat dropped, no strobes, stay in HUNT.
  - din_valid=1 and sof=1: load channel 0 with din, pulse dout_valid[0], slot<=1, go to LOCKED.
- LOCKED, din_valid=1 and sof=0:
  - Load channel[slot] with din and pulse dout_valid[slot].
  - Increment slot; slot wraps from NCH-1 to 0.
  - If slot was NCH-1, also pulse frame_done.
- LOCKED, din_valid=1, sof=1, slot=0: normal frame start; load channel 0, slot<=1, no error.
- LOCKED, din_valid=1, sof=1, slot!=0 (resync):
  - Pulse sync_err.
  - Load channel 0 with din, pulse dout_valid[0], slot<=1, stay in LOCKED.
  - Channels not written in the truncated frame keep their old values.
  - No frame_done for the truncated frame.
- din_valid=0: no register change; sof is ignored; all strobes are 0 next cycle. Idle gaps are allowed mid-frame and slot is held.
- Only one dout_valid bit is high in any cycle. Unwritten channel registers hold their value indefinitely.
- locked mirrors state (LOCKED=1). locked is not cleared by sync_err; only rst returns the block to HUNT.
- rst asserted mid-frame: immediate return to reset values. The partial frame is discarded and the block must see sof again before accepting data.
- NCH=2: slot is 1 bit and wraps 1->0. frame_done accompanies every channel-1 write.

Test Plan:
- Reset check: assert rst for 3 cycles, then release -> dout=0, all strobes 0, locked=0, slot=0.
- HUNT drop: beats 0x11, 0x22 with sof=0 -> no dout_valid, dout stays 0, locked=0.
- Clean frame: beats 0xA0 (sof), 0xA1, 0xA2, 0xA3 on consecutive cycles ->
  - dout_valid pulses 0001, 0010, 0100, 1000 on successive cycles;
  - frame_done with the last pulse;
  - dout = {0xA3, 0xA2, 0xA1, 0xA0};
  - slot returns to 0.
- Gapped frame: beats 0xB0 (sof), idle 2 cycles, 0xB1, idle, 0xB2, 0xB3 -> same strobe sequence stretched over the gaps, slot held through idles, final dout = {0xB3, 0xB2, 0xB1, 0xB0}.
- Resync: sequence 0xC0 (sof), 0xC1, then 0xD0 with sof ->
  - sync_err pulses once, no frame_done;
  - ch0=0xD0, ch1=0xC1, ch2/ch3 unchanged;
  - slot=1 afterwards.
- Mid-frame reset: after 0xE0 (sof) and 0xE1, assert rst asynchronously between clock edges -> outputs zero immediately without waiting for an edge. After release, 0xE2 without sof is dropped and locked=0.

Source files
------------

// File: rtl/tdm_demux.sv
// Receive side of a TDM word stream. Beats are spread across NCH channel registers,
// with a per-channel update strobe and frame/sync status flags.
module tdm_demux #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int CW    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   din,
  input  logic               din_valid,
  input  logic               sof,
  output logic [NCH*WIDTH-1:0] dout,
  output logic [NCH-1:0]     dout_valid,
  output logic               frame_done,
  output logic               sync_err,
  output logic               locked,
  output logic [CW-1:0]      slot
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [CW-1:0]  LAST_SLOT = CW'(NCH - 1);
  localparam logic [CW-1:0]  SLOT_ONE  = CW'(1);
  localparam logic [NCH-1:0] ONE_HOT0  = NCH'(1);

  generate
    if (NCH < 2 || (1 << CW) != NCH) begin : g_bad_param
      $error("tdm_demux: NCH must be a power of 2 >= 2 and CW must equal log2(NCH)");
    end
  endgenerate

  state_t          state_reg;
  logic [CW-1:0]   slot_reg;
  logic [NCH-1:0]  dout_valid_reg;
  logic            frame_done_reg;
  logic            sync_err_reg;
  logic [NCH-1:0]  load_sel;

  // A sof beat always targets channel 0, even as a resync while locked;
  // plain beats are only accepted once locked.
  always_comb begin
    load_sel = '0;
    if (din_valid) begin
      if (sof) begin
        load_sel = ONE_HOT0;
      end else if (state_reg == LOCKED) begin
        load_sel = ONE_HOT0 << slot_reg;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= HUNT;
      slot_reg       <= '0;
      dout_valid_reg <= '0;
      frame_done_reg <= 1'b0;
      sync_err_reg   <= 1'b0;
    end else begin
      dout_valid_reg <= load_sel;
      frame_done_reg <= 1'b0;
      sync_err_reg   <= 1'b0;
      if (din_valid) begin
        case (state_reg)
          HUNT: begin
            if (sof) begin
              state_reg <= LOCKED;
              slot_reg  <= SLOT_ONE;
            end
          end
          LOCKED: begin
            if (sof) begin
              // A truncated frame never reports frame_done.
              sync_err_reg <= (slot_reg != '0);
              slot_reg     <= SLOT_ONE;
            end else begin
              frame_done_reg <= (slot_reg == LAST_SLOT);
              slot_reg       <= slot_reg + SLOT_ONE;
            end
          end
          default: begin
            state_reg <= HUNT;
            slot_reg  <= '0;
          end
        endcase
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan
      logic [WIDTH-1:0] chan_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          chan_reg <= '0;
        end else if (load_sel[gi]) begin
          chan_reg <= din;
        end
      end

      assign dout[gi*WIDTH +: WIDTH] = chan_reg;
    end
  endgenerate

  assign dout_valid = dout_valid_reg;
  assign frame_done = frame_done_reg;
  assign sync_err   = sync_err_reg;
  assign locked     = (state_reg == LOCKED);
  assign slot       = slot_reg;

endmodule
